// File: rtl/dmem_wait.sv
// ---------------------------------------------------------------------------
// dmem_wait -- data memory for the MA stage of the RV32IM pipeline.
//
// Serves byte / half-word / word loads and stores, little-endian. Byte and
// half-word loads are sign- or zero-extended. Each access costs LATENCY
// wait states, reported to the pipeline through the busy stall request.
// Misaligned and out-of-range requests complete at once without touching
// the array. A sticky fault flag and a stall-cycle counter are kept.
//
// Parameters
//   DEPTH      memory size in 32-bit words (>= 1)
//   BASE_ADDR  byte address of word 0 (word aligned)
//   LATENCY    wait states per access (0..15)
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous reset, active low
//   address       byte address
//   data_in       store data (low bytes used for byte/half stores)
//   mem_write     store size: 00 none, 01 byte, 10 half, 11 word
//   mem_read      load size, same encoding
//   load_unsigned 1 = zero-extend byte/half loads, 0 = sign-extend
//   data_out      load result, nonzero only in the completion cycle
//   busy          stall request
//   misaligned    current request is misaligned
//   out_of_range  current request is outside the mapped window
//   fault_sticky  a fault has been seen since reset
//   stall_count   number of busy cycles since reset (wraps)
// ---------------------------------------------------------------------------
module dmem_wait #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [1:0]  mem_write,
    input  logic [1:0]  mem_read,
    input  logic        load_unsigned,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        fault_sticky,
    output logic [31:0] stall_count
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Window end computed on 33 bits so a window touching 2^32 does not wrap.
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        fault_q;
    logic [31:0] stall_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        is_wr, is_rd, req;
    logic [1:0]  size;
    logic        mis_raw, in_range, fault, valid, complete, we;
    logic [32:0] offset;
    logic [AW-1:0] word_idx;
    logic        unused_offset_bits;

    assign is_wr = |mem_write;
    assign is_rd = |mem_read;
    assign req   = is_wr | is_rd;
    // A simultaneous read and write is treated as the write.
    assign size  = is_wr ? mem_write : mem_read;

    assign mis_raw = ((size == 2'b10) && address[0]) ||
                     ((size == 2'b11) && (address[1:0] != 2'b00));

    assign offset   = {1'b0, address} - {1'b0, BASE_ADDR};
    assign in_range = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, address} <  LIMIT);
    assign word_idx = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[32:AW+2], offset[1:0]};

    assign fault = req & (mis_raw | ~in_range);
    assign valid = req & ~fault;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!valid) begin
                    // Request withdrawn (pipeline flush): abandon, no write.
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: byte enables and lane-replicated write data
    // ------------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        be    = 4'b0000;
        wdata = data_in;
        case (mem_write)
            2'b01: begin
                be    = 4'b0001 << address[1:0];
                wdata = {4{data_in[7:0]}};
            end
            2'b10: begin
                be    = address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_in[15:0]}};
            end
            2'b11: begin
                be    = 4'b1111;
                wdata = data_in;
            end
            default: begin
                be    = 4'b0000;
                wdata = data_in;
            end
        endcase
    end

    // Commit only at the edge that ends the completion cycle.
    assign we = reset & complete & is_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] rd_word, load_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_word = mem[word_idx];
    assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (address[1:0])
            2'b00: rd_byte = rd_word[7:0];
            2'b01: rd_byte = rd_word[15:8];
            2'b10: rd_byte = rd_word[23:16];
            2'b11: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    always_comb begin
        load_val = 32'd0;
        case (mem_read)
            2'b01: load_val = load_unsigned ? {24'd0, rd_byte}
                                            : {{24{rd_byte[7]}}, rd_byte};
            2'b10: load_val = load_unsigned ? {16'd0, rd_half}
                                            : {{16{rd_half[15]}}, rd_half};
            2'b11: load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            if (fault) begin
                fault_q <= 1'b1;
            end
            if (busy) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every output reads 0 while reset is held low.
    // ------------------------------------------------------------------
    assign busy         = reset & valid & ~complete;
    assign data_out     = (reset && complete && !is_wr) ? load_val : 32'd0;
    assign misaligned   = reset & req & mis_raw;
    assign out_of_range = reset & req & ~in_range;
    assign fault_sticky = reset & fault_q;
    assign stall_count  = reset ? stall_q : 32'd0;

endmodule

// File: tb/tb_dmem_wait.sv
// ---------------------------------------------------------------------------
// tb_dmem_wait -- scoreboard bench for dmem_wait.
// Two instances share address/data: one with LATENCY=0, one with LATENCY=3.
// Only the selected instance sees a nonzero request. Stimulus pushes the
// expected completion record; a monitor pops it in each completion cycle.
// ---------------------------------------------------------------------------
module tb_dmem_wait;

    logic        clk;
    logic        reset;
    logic [31:0] address, data_in;
    logic [1:0]  mem_write, mem_read;
    logic        load_unsigned;
    logic        sel;

    logic [1:0]  mw0, mr0, mw1, mr1;
    logic [31:0] do0, do1, sc0, sc1;
    logic        busy0, busy1, mis0, mis1, oor0, oor1, stk0, stk1;

    logic [31:0] do_m, sc_m;
    logic        busy_m, mis_m, oor_m, stk_m;

    assign mw0 = sel ? 2'b00 : mem_write;
    assign mr0 = sel ? 2'b00 : mem_read;
    assign mw1 = sel ? mem_write : 2'b00;
    assign mr1 = sel ? mem_read  : 2'b00;

    assign do_m   = sel ? do1   : do0;
    assign sc_m   = sel ? sc1   : sc0;
    assign busy_m = sel ? busy1 : busy0;
    assign mis_m  = sel ? mis1  : mis0;
    assign oor_m  = sel ? oor1  : oor0;
    assign stk_m  = sel ? stk1  : stk0;

    dmem_wait #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .mem_write(mw0), .mem_read(mr0), .load_unsigned(load_unsigned),
        .data_out(do0), .busy(busy0), .misaligned(mis0),
        .out_of_range(oor0), .fault_sticky(stk0), .stall_count(sc0)
    );

    dmem_wait #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .mem_write(mw1), .mem_read(mr1), .load_unsigned(load_unsigned),
        .data_out(do1), .busy(busy1), .misaligned(mis1),
        .out_of_range(oor1), .fault_sticky(stk1), .stall_count(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        oor;
        logic        sticky;
        logic [31:0] stall;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a completion cycle is any cycle with an active request and busy low.
    always @(negedge clk) begin
        if (reset && (mem_read != 2'b00 || mem_write != 2'b00) && !busy_m) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out",     do_m,  mon_e.data);
                chk("misaligned",   {31'd0, mis_m}, {31'd0, mon_e.mis});
                chk("out_of_range", {31'd0, oor_m}, {31'd0, mon_e.oor});
                chk("fault_sticky", {31'd0, stk_m}, {31'd0, mon_e.sticky});
                chk("stall_count",  sc_m,  mon_e.stall);
            end
        end
    end

    task automatic access(input logic [1:0] w, input logic [1:0] r, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input int exp_busy,
                          input logic [31:0] ed, input logic em, input logic eo,
                          input logic es, input logic [31:0] est);
        exp_t x;
        int   nb;
        bit   done;
        x.data = ed; x.mis = em; x.oor = eo; x.sticky = es; x.stall = est;
        sb.push_back(x);
        mem_write = w; mem_read = r; load_unsigned = u; address = a; data_in = d;
        nb = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy_m) done = 1;
            else nb++;
        end
        if (!done) chk("completion_timeout", 32'd0, 32'd1);
        chk("busy_cycles", 32'(nb), 32'(exp_busy));
        @(posedge clk); #1;
        mem_write = 2'b00; mem_read = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; sel = 1'b0; address = '0; data_in = '0;
        mem_write = 2'b00; mem_read = 2'b00; load_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data0",  do0, 32'd0);
        chk("rst_stall0", sc0, 32'd0);
        chk("rst_flags0", {28'd0, busy0, mis0, oor0, stk0}, 32'd0);
        chk("rst_flags1", {28'd0, busy1, mis1, oor1, stk1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ---------------- LATENCY = 0 ----------------
        access(2'b11, 2'b00, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 0);
        access(2'b00, 2'b11, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 0);
        access(2'b01, 2'b00, 0, 32'h11,   32'h80,       0, 32'h0,        0, 0, 0, 0);
        access(2'b00, 2'b01, 0, 32'h11,   32'h0,        0, 32'hFFFFFF80, 0, 0, 0, 0);
        access(2'b00, 2'b01, 1, 32'h11,   32'h0,        0, 32'h00000080, 0, 0, 0, 0);
        access(2'b00, 2'b10, 0, 32'h10,   32'h0,        0, 32'hFFFF80EF, 0, 0, 0, 0);
        access(2'b00, 2'b10, 1, 32'h12,   32'h0,        0, 32'h0000DEAD, 0, 0, 0, 0);
        access(2'b00, 2'b11, 0, 32'h12,   32'h0,        0, 32'h0,        1, 0, 0, 0);
        access(2'b00, 2'b11, 0, 32'h10,   32'h0,        0, 32'hDEAD80EF, 0, 0, 1, 0);
        access(2'b11, 2'b00, 0, 32'h1000, 32'h12345678, 0, 32'h0,        0, 1, 1, 0);
        access(2'b00, 2'b11, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 1, 0);
        access(2'b10, 2'b00, 0, 32'h2,    32'hA5A51234, 0, 32'h0,        0, 0, 1, 0);
        access(2'b00, 2'b11, 0, 32'h0,    32'h0,        0, 32'h12340000, 0, 0, 1, 0);
        access(2'b11, 2'b11, 0, 32'h10,   32'h11111111, 0, 32'h0,        0, 0, 1, 0);
        access(2'b00, 2'b11, 0, 32'h10,   32'h0,        0, 32'h11111111, 0, 0, 1, 0);
        access(2'b00, 2'b01, 0, 32'hFFF,  32'h0,        0, 32'h0,        0, 0, 1, 0);

        // ---------------- LATENCY = 3 ----------------
        sel = 1'b1;
        access(2'b11, 2'b00, 0, 32'h10, 32'hDEADBEEF, 3, 32'h0,        0, 0, 0, 3);
        access(2'b00, 2'b11, 0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 0, 0, 0, 6);

        // Flush: store dropped after one busy cycle.
        mem_write = 2'b11; address = 32'h10; data_in = 32'hCAFEF00D;
        @(negedge clk); chk("flush_busy", {31'd0, busy_m}, 32'd1);
        @(posedge clk); #1; mem_write = 2'b00;
        @(negedge clk); chk("flush_stall", sc_m, 32'd7);
        @(posedge clk); #1;
        access(2'b00, 2'b11, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 0, 0, 10);
        access(2'b00, 2'b10, 0, 32'h11, 32'h0, 0, 32'h0,        1, 0, 0, 10);

        // Reset asserted during WAIT.
        mem_write = 2'b11; address = 32'h20; data_in = 32'h55;
        @(negedge clk); chk("rstw_busy", {31'd0, busy_m}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rstw_data",  do_m, 32'd0);
        chk("rstw_stall", sc_m, 32'd0);
        chk("rstw_flags", {28'd0, busy_m, mis_m, oor_m, stk_m}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1; mem_write = 2'b00;
        access(2'b00, 2'b11, 0, 32'h10, 32'h0, 3, 32'h0, 0, 0, 0, 3);
        access(2'b00, 2'b11, 0, 32'h20, 32'h0, 3, 32'h0, 0, 0, 0, 6);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_wait.md
# dmem_wait

Parametrised data-memory block for the RV32IM pipeline's memory-access (MA) stage. It serves loads and stores on byte, half-word and word boundaries, with sign or zero extension on loads. A programmable number of wait states is reported to the pipeline through a `busy` stall output. It also flags misaligned and out-of-range accesses, keeps a sticky fault status and counts stall cycles, so cache/bus latency can be modelled before a real memory system exists.

## Interface
Parameters:
- `DEPTH`, default 1024: memory size in 32-bit words; any value ≥ 1.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be word-aligned.
- `LATENCY`, default 0: wait states per access; legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `address`, input, 32: byte address from MA-stage ALU result.
- `data_in`, input, 32: store data; the low bytes are used for byte and half-word stores.
- `mem_write`, input, 2: store size: 00 none, 01 byte, 10 half-word, 11 word.
- `mem_read`, input, 2: load size, same encoding as `mem_write`.
- `load_unsigned`, input, 1: 1 means zero-extend byte/half loads; 0 means sign-extend.
- `data_out`, output, 32: load result.
- `busy`, output, 1: stall request to the pipeline.
- `misaligned`, output, 1: current request is misaligned.
- `out_of_range`, output, 1: current request is outside `[BASE_ADDR, BASE_ADDR+4*DEPTH)`.
- `fault_sticky`, output, 1: a fault has occurred since reset.
- `stall_count`, output, 32: total cycles with `busy`=1 since reset.

## Operation
- **Request:** `req` = (`mem_read` != 0) or (`mem_write` != 0).
- **Read and write together:** if both are nonzero, the write wins and `data_out` = 0.
- **Byte lanes:** little-endian; lane selected by `address[1:0]`.
  - Byte store writes lane `address[1:0]` only.
  - Half-word store writes lanes `{address[1],0}` and `{address[1],1}`.
  - Word store writes all four lanes.
- **Loads:** byte and half-word values are extended per `load_unsigned`. Word loads ignore `load_unsigned`.
- **Array read is combinational:** `data_out` is valid only in the completion cycle (defined below) and is 0 otherwise.
- **Faults:**
  - `misaligned` = half-word with `address[0]`=1, or word with `address[1:0]` != 0.
  - `out_of_range` is computed from the full 32-bit compare.
  - Both flags are combinational and gated by `req`.
  - A faulting request completes immediately: `busy` = 0, no write, `data_out` = 0, FSM stays IDLE.
  - `fault_sticky` is set at the edge of any faulting cycle and is cleared only by reset.
- **FSM states:** IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE, valid `req`, `LATENCY` > 0: go to WAIT, `cnt` ← `LATENCY`−1.
  - IDLE, valid `req`, `LATENCY` = 0: completes this cycle; stay IDLE.
  - WAIT, `req` still high, `cnt` != 0: `cnt` ← `cnt`−1.
  - WAIT, `req` still high, `cnt` = 0: completion cycle; go to IDLE.
  - WAIT, `req` dropped (flush): abort, go to IDLE, no write.
- **Busy and completion:**
  - `busy` = valid `req` and not a completion cycle. It is combinational and forced to 0 while `reset`=0.
  - Completion cycle = IDLE with `LATENCY`=0, or WAIT with `cnt`=0.
- **Write commit:** stores commit at the rising edge ending the completion cycle, never earlier.
- **Request stability:** the pipeline must hold `address`, `data_in` and sizes stable while `busy`=1. Behaviour when a request changes mid-WAIT is undefined, except for the flush case.
- **`stall_count`:** increments by 1 on every edge where `busy`=1; wraps modulo 2^32.

## Timing
- **Reset** (`reset`=0 at an edge):
  - state ← IDLE, `cnt` ← 0, `fault_sticky` ← 0, `stall_count` ← 0.
  - All `DEPTH` words are cleared to 0.
  - Writes are ignored during reset.
  - While `reset`=0, all outputs read 0.
  - A reset asserted mid-WAIT aborts the access with no write.
- **Stall length:** an access issued in cycle T0 holds `busy`=1 in T0..T(`LATENCY`−1) and completes in T(`LATENCY`). That is exactly `LATENCY` stall cycles per access.
- **Back-to-back requests:** the cycle after a completion is in IDLE, so a back-to-back request is a fresh access with full latency.
- **Store-to-load:** a load issued the cycle after a completing store to the same word returns the new data.

## Test plan
- **Basic word access, `LATENCY`=0:** release reset; word store 32'hDEADBEEF at 0x10, then word load at 0x10 → `data_out`=32'hDEADBEEF in the same cycle, `busy` never high.
- **Byte/half with extension:** after the above, byte store 8'h80 at 0x11.
  - Byte load 0x11 with `load_unsigned`=0 → 32'hFFFFFF80; with `load_unsigned`=1 → 32'h00000080.
  - Half-word load 0x10 → 32'hFFFF80EF.
- **Wait states, `LATENCY`=3:** load at 0x10 → `busy`=1 for 3 cycles, data valid in the 4th, `stall_count`=3. A store in those 3 cycles has not committed until the edge ending cycle 4.
- **Faults:** word load at 0x12 → `misaligned`=1, `busy`=0, `data_out`=0, `fault_sticky`=1 next cycle. Store at `BASE_ADDR`+4*`DEPTH` → `out_of_range`=1, memory unchanged.
- **Flush and reset mid-access, `LATENCY`=3:**
  - Store issued, request dropped after 1 busy cycle → target word unchanged, FSM IDLE.
  - Repeat with `reset`=0 during WAIT → all outputs 0, memory cleared, `stall_count`=0.
